// File: rtl/bresenham_line_drawer.sv
// rtl/bresenham_line_drawer.sv - integer Bresenham line rasterizer with valid/ready pixel stream
module bresenham_line_drawer #(
  parameter int COORD_W = 10
) (
  input  logic               i_clk,
  input  logic               i_n_rst,
  input  logic               i_draw_en,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y1,
  output logic [COORD_W-1:0] o_pixel_x,
  output logic [COORD_W-1:0] o_pixel_y,
  output logic               o_pixel_valid,
  input  logic               i_pixel_ready,
  output logic               o_draw_done,
  output logic               o_busy
);

  // Two extra bits: one for sign, one so that 2*err cannot overflow.
  localparam int ERR_W = COORD_W + 2;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PLOT  = 3'd2,
    S_DONE  = 3'd3,
    S_REARM = 3'd4
  } state_t;

  state_t                    r_state;
  logic [COORD_W-1:0]        r_x0, r_y0, r_x1, r_y1;
  logic [COORD_W-1:0]        r_x, r_y;
  logic signed [ERR_W-1:0]   r_dx, r_dy, r_err;
  logic                      r_sx, r_sy;
  logic                      r_valid, r_done, r_busy;

  logic [COORD_W-1:0]        w_abs_dx, w_abs_dy;
  logic signed [ERR_W-1:0]   w_dx, w_dy, w_e2, w_err_step;
  logic                      w_step_x, w_step_y, w_at_end, w_accept;

  // Setup terms from latched endpoints and the per-pixel step decision.
  always_comb begin
    w_abs_dx   = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    w_abs_dy   = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
    w_dx       = $signed({2'b00, w_abs_dx});
    w_dy       = -$signed({2'b00, w_abs_dy});
    w_e2       = r_err <<< 1;
    w_step_x   = (w_e2 >= r_dy);
    w_step_y   = (w_e2 <= r_dx);
    // Both increments apply to the pre-step error and accumulate.
    w_err_step = r_err;
    if (w_step_x) w_err_step = w_err_step + r_dy;
    if (w_step_y) w_err_step = w_err_step + r_dx;
    w_at_end   = (r_x == r_x1) && (r_y == r_y1);
    w_accept   = r_valid & i_pixel_ready;
  end

  // Request handshake, setup, plotting and rearm sequencing.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state <= S_IDLE;
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_err   <= '0;
      r_sx    <= 1'b0;
      r_sy    <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_draw_en) begin
            r_x0    <= i_x0;
            r_y0    <= i_y0;
            r_x1    <= i_x1;
            r_y1    <= i_y1;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (!i_draw_en) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_dx    <= w_dx;
            r_dy    <= w_dy;
            r_err   <= w_dx + w_dy;
            r_sx    <= (r_x0 < r_x1);
            r_sy    <= (r_y0 < r_y1);
            r_x     <= r_x0;
            r_y     <= r_y0;
            r_valid <= 1'b1;
            r_state <= S_PLOT;
          end
        end
        S_PLOT: begin
          if (!i_draw_en) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_accept) begin
            if (w_at_end) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err <= w_err_step;
              if (w_step_x) r_x <= r_sx ? (r_x + ONE) : (r_x - ONE);
              if (w_step_y) r_y <= r_sy ? (r_y + ONE) : (r_y - ONE);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_REARM;
        end
        S_REARM: begin
          if (!i_draw_en) r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pixel_x     = r_x;
  assign o_pixel_y     = r_y;
  assign o_pixel_valid = r_valid;
  assign o_draw_done   = r_done;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// tb/tb_bresenham_line_drawer.sv - directed table-driven bench for bresenham_line_drawer
module tb_bresenham_line_drawer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       draw_en;
  logic [9:0] x0, y0, x1, y1;
  logic [9:0] pixel_x, pixel_y;
  logic       pixel_valid;
  logic       pixel_ready;
  logic       draw_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bresenham_line_drawer #(.COORD_W(10)) dut (
    .i_clk         (clk),
    .i_n_rst       (n_rst),
    .i_draw_en     (draw_en),
    .i_x0          (x0),
    .i_y0          (y0),
    .i_x1          (x1),
    .i_y1          (y1),
    .o_pixel_x     (pixel_x),
    .o_pixel_y     (pixel_y),
    .o_pixel_valid (pixel_valid),
    .i_pixel_ready (pixel_ready),
    .o_draw_done   (draw_done),
    .o_busy        (busy)
  );

  typedef struct {
    logic [9:0]       x0, y0, x1, y1;
    int               n;
    logic [7:0][19:0] pix;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [19:0] px(input int x, input int y);
    return {10'(x), 10'(y)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full request with ready tied high, checking exact cycle timing.
  task automatic run_line(input string tag, input logic [9:0] ax0, input logic [9:0] ay0,
                          input logic [9:0] ax1, input logic [9:0] ay1, input int n,
                          input logic [7:0][19:0] pix);
    @(negedge clk);
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
    draw_en = 1'b1;
    pixel_ready = 1'b1;
    @(negedge clk);
    x0 = 10'h3ff; y0 = 10'h155; x1 = 10'h2aa; y1 = 10'h3ff;
    check({tag, "_setup_busy"}, busy, 1);
    check({tag, "_setup_valid"}, pixel_valid, 0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("%s_valid%0d", tag, k), pixel_valid, 1);
      check($sformatf("%s_x%0d", tag, k), pixel_x, pix[k][19:10]);
      check($sformatf("%s_y%0d", tag, k), pixel_y, pix[k][9:0]);
      check($sformatf("%s_busy%0d", tag, k), busy, 1);
      check($sformatf("%s_nodone%0d", tag, k), draw_done, 0);
    end
    @(negedge clk);
    check({tag, "_done"}, draw_done, 1);
    check({tag, "_done_valid"}, pixel_valid, 0);
    check({tag, "_done_busy"}, busy, 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, draw_done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    draw_en = 1'b0;
    @(negedge clk);
    check({tag, "_rearm_busy"}, busy, 0);
  endtask

  initial begin
    logic [7:0][19:0] p;
    int acc, bad;
    bit held, prev_acc, got_done;
    logic [9:0] hx, hy;

    tbl[0].x0 = 0; tbl[0].y0 = 0; tbl[0].x1 = 4; tbl[0].y1 = 0; tbl[0].n = 5;
    tbl[0].pix = '0;
    for (int k = 0; k < 5; k++) tbl[0].pix[k] = px(k, 0);
    tbl[1].x0 = 0; tbl[1].y0 = 0; tbl[1].x1 = 3; tbl[1].y1 = 1; tbl[1].n = 4;
    tbl[1].pix = '0;
    tbl[1].pix[0] = px(0, 0); tbl[1].pix[1] = px(1, 0);
    tbl[1].pix[2] = px(2, 1); tbl[1].pix[3] = px(3, 1);
    tbl[2].x0 = 3; tbl[2].y0 = 1; tbl[2].x1 = 0; tbl[2].y1 = 0; tbl[2].n = 4;
    tbl[2].pix = '0;
    tbl[2].pix[0] = px(3, 1); tbl[2].pix[1] = px(2, 1);
    tbl[2].pix[2] = px(1, 0); tbl[2].pix[3] = px(0, 0);
    tbl[3].x0 = 0; tbl[3].y0 = 0; tbl[3].x1 = 1; tbl[3].y1 = 3; tbl[3].n = 4;
    tbl[3].pix = '0;
    tbl[3].pix[0] = px(0, 0); tbl[3].pix[1] = px(0, 1);
    tbl[3].pix[2] = px(1, 2); tbl[3].pix[3] = px(1, 3);
    tbl[4].x0 = 5; tbl[4].y0 = 5; tbl[4].x1 = 2; tbl[4].y1 = 2; tbl[4].n = 4;
    tbl[4].pix = '0;
    for (int k = 0; k < 4; k++) tbl[4].pix[k] = px(5 - k, 5 - k);
    tbl[5].x0 = 7; tbl[5].y0 = 9; tbl[5].x1 = 7; tbl[5].y1 = 9; tbl[5].n = 1;
    tbl[5].pix = '0;
    tbl[5].pix[0] = px(7, 9);

    n_rst = 1'b0; draw_en = 1'b0; pixel_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #12;
    check("rst_x", pixel_x, 0);
    check("rst_y", pixel_y, 0);
    check("rst_valid", pixel_valid, 0);
    check("rst_done", draw_done, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 6; i++)
      run_line($sformatf("vec%0d", i), tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1,
               tbl[i].n, tbl[i].pix);

    // Backpressure on a vertical line, ready low every other cycle.
    @(negedge clk);
    x0 = 0; y0 = 0; x1 = 0; y1 = 3; draw_en = 1'b1; pixel_ready = 1'b0;
    @(negedge clk);
    acc = 0; held = 0; prev_acc = 0; got_done = 0; hx = '0; hy = '0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(negedge clk);
      if (draw_done) begin
        got_done = 1;
        check("bp_done_after_accept", 32'(prev_acc), 1);
        check("bp_accept_count", acc, 4);
      end else begin
        if (held) begin
          check("bp_hold_x", pixel_x, hx);
          check("bp_hold_y", pixel_y, hy);
        end
        held = 0; prev_acc = 0;
        if (pixel_valid) begin
          pixel_ready = c[0];
          if (pixel_ready) begin
            check($sformatf("bp_x%0d", acc), pixel_x, 0);
            check($sformatf("bp_y%0d", acc), pixel_y, acc);
            acc++;
            prev_acc = 1;
          end else begin
            held = 1; hx = pixel_x; hy = pixel_y;
          end
        end
      end
    end
    check("bp_done_seen", 32'(got_done), 1);
    pixel_ready = 1'b1;
    @(negedge clk);
    draw_en = 1'b0;
    @(negedge clk);

    // Degenerate line with draw_en held high after the pulse.
    @(negedge clk);
    x0 = 7; y0 = 9; x1 = 7; y1 = 9; draw_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("deg_x", pixel_x, 7);
    check("deg_y", pixel_y, 9);
    check("deg_valid", pixel_valid, 1);
    @(negedge clk);
    check("deg_done", draw_done, 1);
    x0 = 1; y0 = 1; x1 = 2; y1 = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("deg_hold_busy%0d", c), busy, 0);
      check($sformatf("deg_hold_valid%0d", c), pixel_valid, 0);
      check($sformatf("deg_hold_done%0d", c), draw_done, 0);
    end
    draw_en = 1'b0;
    p = '0; p[0] = px(1, 1); p[1] = px(2, 1);
    run_line("after_deg", 1, 1, 2, 1, 2, p);

    // Extreme anti-diagonal across the full coordinate range.
    @(negedge clk);
    x0 = 1023; y0 = 0; x1 = 0; y1 = 1023; draw_en = 1'b1; pixel_ready = 1'b1;
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      if (!pixel_valid || pixel_x !== 10'(1023 - k) || pixel_y !== 10'(k)) bad++;
    end
    check("diag_bad_pixels", bad, 0);
    check("diag_last_x", pixel_x, 0);
    check("diag_last_y", pixel_y, 1023);
    @(negedge clk);
    check("diag_done", draw_done, 1);
    @(negedge clk);
    draw_en = 1'b0;
    @(negedge clk);

    // Asynchronous reset during PLOT.
    @(negedge clk);
    x0 = 0; y0 = 0; x1 = 9; y1 = 0; draw_en = 1'b1;
    repeat (4) @(negedge clk);
    check("prerst_x", pixel_x, 2);
    #2;
    n_rst = 1'b0;
    draw_en = 1'b0;
    #1;
    check("midrst_x", pixel_x, 0);
    check("midrst_y", pixel_y, 0);
    check("midrst_valid", pixel_valid, 0);
    check("midrst_done", draw_done, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("postrst_busy", busy, 0);
    check("postrst_valid", pixel_valid, 0);

    // Abort mid-line, then a fresh request.
    @(negedge clk);
    x0 = 0; y0 = 0; x1 = 9; y1 = 0; draw_en = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_pre_valid", pixel_valid, 1);
    draw_en = 1'b0;
    @(negedge clk);
    check("abort_valid", pixel_valid, 0);
    check("abort_busy", busy, 0);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("abort_nodone%0d", c), draw_done, 0);
      @(negedge clk);
    end
    p = '0; p[0] = px(2, 3); p[1] = px(3, 3); p[2] = px(4, 3);
    run_line("after_abort", 2, 3, 4, 3, 3, p);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bresenham_line_drawer.md
# bresenham_line_drawer

Line-rasterization engine that answers the draw_en / draw_done handshake issued by the Bresenham sequencing controller. It rasterizes one line segment per request using the integer Bresenham algorithm and streams pixel coordinates to the frame-buffer writer under a valid/ready handshake. When the last pixel is accepted, it returns a one-cycle draw_done pulse to the controller.

## Interface
- COORD_W, default 10: width of each unsigned coordinate (0 .. 2^COORD_W-1).
- clk  input  1  system clock; all state changes on its rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- draw_en  input  1  level request from the controller; held high until draw_done is seen.
- x0, y0  input  COORD_W each  start point; sampled on the accepting edge only.
- x1, y1  input  COORD_W each  end point; sampled on the accepting edge only.
- pixel_x, pixel_y  output  COORD_W each  current pixel coordinate.
- pixel_valid  output  1  pixel_x/pixel_y hold a pixel to be written.
- pixel_ready  input  1  frame-buffer writer accepts the pixel this cycle.
- draw_done  output  1  one-cycle pulse after the last pixel is accepted.
- busy  output  1  high in SETUP, PLOT and DONE.

## Operation
- Reset: state = IDLE. pixel_x = pixel_y = 0; pixel_valid, draw_done and busy = 0; internal registers cleared.
- State machine:
  - IDLE: when draw_en = 1, latch x0/y0/x1/y1 and go to SETUP.
  - SETUP: register the algorithm terms, then go to PLOT.
    - dx = |x1-x0|, dy = -|y1-y0|.
    - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
    - err = dx+dy; current point = (x0, y0).
  - PLOT: pixel_valid = 1 and pixel_x/pixel_y = current point.
    - Accept means pixel_valid & pixel_ready.
    - On accept at the endpoint (x == x1 && y == y1): go to DONE.
    - On accept elsewhere, step with e2 = 2*err:
      - if e2 >= dy: err += dy and x += sx;
      - if e2 <= dx: err += dx and y += sy;
      - both updates use the pre-step err, and the two err increments sum.
    - Without accept: hold the point, err and outputs stable.
  - DONE: draw_done = 1 for exactly one cycle, then go to REARM.
  - REARM: wait for draw_en = 0, then go to IDLE. This prevents re-triggering on the same request level.
- Arithmetic: err and e2 are signed COORD_W+2 bits. Coordinates never leave the [min, max] range of the endpoints; no wrap can occur.
- Pixel count per line: N = max(dx, -dy) + 1. The endpoint is always emitted.
- Degenerate line (x0==x1 && y0==y1): exactly one pixel, then DONE.
- Abort: if draw_en = 0 while in SETUP or PLOT:
  - go to IDLE on the next edge;
  - pixel_valid drops;
  - no draw_done is issued.
  - The writer tolerates withdrawn valid on abort.
- Endpoint inputs changing after the accepting edge are ignored until the next request.
- Asynchronous reset mid-line returns everything to reset values immediately. No pulse is issued.

## Timing
- Edge E0 samples draw_en = 1 in IDLE. SETUP runs in cycle E0..E1.
- pixel k (0-based) is presented from edge E1+k when pixel_ready is tied high. Throughput is one pixel per cycle.
- With pixel_ready = 1 throughout:
  - last accept at edge E0+N+1;
  - draw_done high in cycle E0+N+1..E0+N+2.
- Each cycle of pixel_ready = 0 in PLOT adds exactly one cycle of latency.
- Controller interaction: the controller drops draw_en for one cycle after seeing draw_done. That low cycle, seen in REARM, returns the drawer to IDLE. The next request is accepted on the following edge with draw_en high.
- Minimum turnaround from draw_done to the next accepting edge: 3 edges.
- All outputs are registered or decoded from state and registers only. There is no combinational path from pixel_ready or draw_en to any output.

## Test plan
- Horizontal line (0,0)->(4,0), ready = 1:
  - pixels x = 0,1,2,3,4 with y = 0 on consecutive cycles;
  - draw_done one cycle at E0+6;
  - busy high E0..E0+7.
- Shallow line (0,0)->(3,1): pixels (0,0),(1,0),(2,1),(3,1). Reversed (3,1)->(0,0): pixels (3,1),(2,1),(1,0),(0,0).
- Backpressure, (0,0)->(0,3) with pixel_ready low every other cycle:
  - pixel held stable while ready is low;
  - 4 accepted pixels (0,0)..(0,3), no duplicates;
  - draw_done follows the 4th accept by 1 cycle.
- Degenerate (7,9)->(7,9): a single pixel (7,9), then draw_done. Holding draw_en high after the pulse produces no second line until draw_en is low for at least 1 cycle.
- Extremes, COORD_W = 10, (1023,0)->(0,1023): 1024 diagonal pixels ending at (0,1023), with no sign or overflow error.
- Reset and abort:
  - n_rst low during PLOT of (0,0)->(9,0): all outputs 0 immediately and state IDLE.
  - Separately, draw_en dropped mid-line: pixel_valid falls the next cycle, draw_done never pulses, and a new request starts from fresh endpoints.
